alto_wakeup_controller: RTL and testbench



---
 rtl/alto_wakeup_controller.sv | 53 +++++
 tb/tb_alto_wakeup_controller.sv | 126 ++++++++++++
 2 files changed

// File: rtl/alto_wakeup_controller.sv
// alto_wakeup_controller: per-task wakeup request vector with pulse latches, level pass-through, refresh timer and BLOCK retire.
// Optional sticky overrun flags are enabled by defining ALTO_WAKEUP_OVERRUN_EN.
module alto_wakeup_controller #(
  parameter logic [15:0] LEVEL_MASK     = 16'h0000,
  parameter int          REFRESH_TASK   = 8,
  parameter int          REFRESH_PERIOD = 38
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] wakeup_pulse_i,
  input  logic [15:0] wakeup_level_i,
  input  logic [15:0] wakeup_enable_i,
  input  logic [3:0]  current_task_i,
  input  logic [3:0]  f1_i,
  input  logic        stall_i,
`ifdef ALTO_WAKEUP_OVERRUN_EN
  input  logic        overrun_clr_i,
  output logic [15:0] overrun_o,
`endif
  output logic [15:0] task_request_o
);
  localparam logic [11:0] RELOAD = 12'(REFRESH_PERIOD - 1);
  localparam logic [15:0] REFRESH_BIT = 16'd1 << REFRESH_TASK;
  logic [11:0] cnt;
  logic        fire;
  logic        block_hit;
  logic [15:0] fire_vec, set_vec, blk_vec, req_next;
  always_comb begin
    fire      = cnt == 12'd0;
    block_hit = f1_i == 4'd3 && !stall_i && current_task_i != 4'd0;
    fire_vec  = fire ? REFRESH_BIT : 16'h0000;
    // task 0 is never latched; level tasks never take pulses or refresh
    set_vec   = (wakeup_pulse_i | fire_vec) & wakeup_enable_i & ~LEVEL_MASK & 16'hFFFE;
    blk_vec   = block_hit ? 16'd1 << current_task_i : 16'h0000;
    req_next  = (wakeup_enable_i & ~LEVEL_MASK & (set_vec | (task_request_o & ~blk_vec)))
              | (wakeup_level_i & wakeup_enable_i & LEVEL_MASK) | 16'h0001;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt            <= RELOAD;
      task_request_o <= 16'h0001;
    end else begin
      cnt            <= fire ? RELOAD : cnt - 12'd1;
      task_request_o <= req_next;
    end
  end
`ifdef ALTO_WAKEUP_OVERRUN_EN
  always_ff @(posedge clk_i) begin
    if (rst_i || overrun_clr_i) overrun_o <= 16'h0000;
    else overrun_o <= overrun_o | (set_vec & task_request_o & ~blk_vec);
  end
`endif
endmodule

// File: tb/tb_alto_wakeup_controller.sv
// tb_alto_wakeup_controller: directed and random checks of alto_wakeup_controller against a per-task behavioural model.
module tb_alto_wakeup_controller;
  localparam logic [15:0] LM = 16'h4000;
  localparam int RT = 8;
  localparam int RP = 38;
  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [15:0] wakeup_pulse_i = '0, wakeup_level_i = '0, wakeup_enable_i = '0;
  logic [3:0]  current_task_i = '0, f1_i = '0;
  logic        stall_i = 1'b0;
  logic        overrun_clr_i = 1'b0;
  logic [15:0] task_request_o;
  logic [15:0] m, mo;
  int          k, n_chk, n_fail;
`ifdef ALTO_WAKEUP_OVERRUN_EN
  logic [15:0] overrun_o;
`endif
  alto_wakeup_controller #(.LEVEL_MASK(LM), .REFRESH_TASK(RT), .REFRESH_PERIOD(RP)) dut (
    .clk_i(clk), .rst_i(rst_i), .wakeup_pulse_i(wakeup_pulse_i), .wakeup_level_i(wakeup_level_i),
    .wakeup_enable_i(wakeup_enable_i), .current_task_i(current_task_i), .f1_i(f1_i), .stall_i(stall_i),
`ifdef ALTO_WAKEUP_OVERRUN_EN
    .overrun_clr_i(overrun_clr_i), .overrun_o(overrun_o),
`endif
    .task_request_o(task_request_o));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic do_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    m = 16'h0001; mo = '0; k = 0;
    check("reset_req", task_request_o, 16'h0001);
`ifdef ALTO_WAKEUP_OVERRUN_EN
    check("reset_ovr", overrun_o, 16'h0000);
`endif
  endtask
  task automatic cyc(input logic [15:0] p, input logic [15:0] lv, input logic [15:0] en,
                     input logic [3:0] ct, input logic [3:0] f, input logic st, input logic clr);
    logic fire, blk;
    wakeup_pulse_i = p; wakeup_level_i = lv; wakeup_enable_i = en;
    current_task_i = ct; f1_i = f; stall_i = st; overrun_clr_i = clr;
    @(posedge clk);
    fire = (k % RP) == RP - 1;
    blk  = f == 4'd3 && !st && ct != 4'd0;
    for (int t = 1; t < 16; t++) begin
      if (LM[t]) m[t] = lv[t] & en[t];
      else if (!en[t]) m[t] = 1'b0;
      else if (p[t] || (fire && t == RT)) begin
        if (m[t] && !(blk && ct == t)) mo[t] = 1'b1;
        m[t] = 1'b1;
      end else if (blk && ct == t) m[t] = 1'b0;
    end
    if (clr) mo = '0;
    k++;
    #1;
    check("req", task_request_o, m);
`ifdef ALTO_WAKEUP_OVERRUN_EN
    check("ovr", overrun_o, mo);
`endif
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc('0, '0, 16'hFFFF, 4'd0, 4'd0, 1'b0, 1'b0);
  endtask
  initial begin
    n_chk = 0; n_fail = 0;
    do_reset();
    idle(37);
    check("ref_early", 16'(task_request_o[8]), 16'd0);
    idle(1);
    check("ref_first", 16'(task_request_o[8]), 16'd1);
    cyc('0, '0, 16'hFFFF, 4'd8, 4'd3, 1'b0, 1'b0);
    check("ref_block", 16'(task_request_o[8]), 16'd0);
    idle(36);
    check("ref2_early", 16'(task_request_o[8]), 16'd0);
    idle(1);
    check("ref2", 16'(task_request_o[8]), 16'd1);
    cyc(16'h0010, '0, 16'hFFFF, 4'd0, 4'd0, 1'b0, 1'b0);
    check("pulse4", 16'(task_request_o[4]), 16'd1);
    idle(3);
    cyc('0, '0, 16'hFFFF, 4'd4, 4'd3, 1'b0, 1'b0);
    check("block4", 16'(task_request_o[4]), 16'd0);
    cyc(16'h0010, '0, 16'hFFFF, 4'd0, 4'd0, 1'b0, 1'b0);
    cyc('0, '0, 16'hFFFF, 4'd4, 4'd3, 1'b1, 1'b0);
    check("stall4", 16'(task_request_o[4]), 16'd1);
    cyc('0, '0, 16'hFFFF, 4'd4, 4'd3, 1'b0, 1'b0);
    check("stall4_ret", 16'(task_request_o[4]), 16'd0);
    cyc(16'h0010, '0, 16'hFFFF, 4'd4, 4'd3, 1'b0, 1'b0);
    check("set_wins", 16'(task_request_o[4]), 16'd1);
    cyc('0, '0, 16'hFFFF, 4'd4, 4'd3, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc('0, 16'h4000, 16'hFFFF, 4'd14, 4'd3, 1'b0, 1'b0);
      check("level14", 16'(task_request_o[14]), 16'd1);
    end
    idle(1);
    check("level14_off", 16'(task_request_o[14]), 16'd0);
    cyc(16'h0010, '0, 16'hFFEF, 4'd0, 4'd0, 1'b0, 1'b0);
    check("gate4", 16'(task_request_o[4]), 16'd0);
    cyc('0, '0, 16'hFFFF, 4'd0, 4'd3, 1'b0, 1'b0);
    check("emu", 16'(task_request_o[0]), 16'd1);
    cyc(16'h0080, '0, 16'hFFFF, 4'd0, 4'd0, 1'b0, 1'b0);
    cyc(16'h0080, '0, 16'hFFFF, 4'd0, 4'd0, 1'b0, 1'b0);
`ifdef ALTO_WAKEUP_OVERRUN_EN
    check("ovr7", 16'(overrun_o[7]), 16'd1);
    cyc('0, '0, 16'hFFFF, 4'd0, 4'd0, 1'b0, 1'b1);
    check("ovr_clr", overrun_o, 16'h0000);
`endif
    cyc('0, '0, 16'hFFFF, 4'd7, 4'd3, 1'b0, 1'b0);
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 1500; i++) begin
        cyc(($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'h0000, 16'($urandom),
            ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'hFFFF, 4'($urandom),
            ($urandom_range(0, 1) == 0) ? 4'd3 : 4'($urandom), $urandom_range(0, 3) == 0,
            $urandom_range(0, 15) == 0);
      end
      if (pass == 0) do_reset();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
